mdu_seq: RTL and testbench

- Iterative multiply/divide unit with its own sequencing FSM for the RV32M instructions produced by the decoder.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
- Uses a valid/ready handshake on both sides so the core stalls issue while the unit is busy.
- Carries the destination register tag through to writeback.

---
 rtl/mdu_seq_if.sv | 29 ++
 rtl/mdu_seq.sv | 150 +++++++++++++++
 tb/tb_mdu_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_if.sv
// Request/response bundle between the issue stage and the iterative multiply/divide unit.
interface mdu_seq_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned RW = 5;

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [RW-1:0]   rd_in;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [RW-1:0]   rd_out;
    logic            busy;

    modport master (
        output in_valid, op, src1, src2, rd_in, flush, out_ready,
        input  in_ready, out_valid, result, rd_out, busy
    );

    modport slave (
        input  in_valid, op, src1, src2, rd_in, flush, out_ready,
        output in_ready, out_valid, result, rd_out, busy
    );
endinterface

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with sign fix-up folded into the final iteration.
module mdu_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    mdu_seq_if.slave   bus
);
    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam int unsigned RW = 5;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic [RW-1:0]     rd_q;
    logic              sign_a_q, sign_b_q;
    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   rem_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   result_q;

    logic              accept_c, last_c, div_zero_c, ovf_c, sgn_a_c, sgn_b_c;
    logic [XLEN-1:0]   mag_a_c, mag_b_c, fast_res_c;
    logic [XLEN:0]     mul_add_c, div_shift_c;
    logic [2*XLEN-1:0] mul_acc_c, prod_fix_c;
    logic              div_ge_c;
    logic [XLEN-1:0]   quo_c, rem_c, mul_res_c, div_res_c;

    // Request decode: operand signedness, magnitudes and fast-path detection
    always_comb begin
        accept_c   = bus.in_valid & bus.in_ready & ~bus.flush;
        sgn_a_c    = ((bus.op == 3'b001) | (bus.op == 3'b010) | (bus.op == 3'b100) | (bus.op == 3'b110))
                     & bus.src1[XLEN-1];
        sgn_b_c    = ((bus.op == 3'b001) | (bus.op == 3'b100) | (bus.op == 3'b110)) & bus.src2[XLEN-1];
        mag_a_c    = sgn_a_c ? XLEN'(~bus.src1 + XLEN'(1)) : bus.src1;
        mag_b_c    = sgn_b_c ? XLEN'(~bus.src2 + XLEN'(1)) : bus.src2;
        div_zero_c = bus.op[2] & (bus.src2 == '0);
        ovf_c      = bus.op[2] & ~bus.op[0] & (bus.src1 == {1'b1, {(XLEN-1){1'b0}}}) & (bus.src2 == '1);
        fast_res_c = '0;
        if (div_zero_c)
            fast_res_c = bus.op[1] ? bus.src1 : '1;
        else if (!bus.op[1])
            fast_res_c = {1'b1, {(XLEN-1){1'b0}}};
    end

    // One iteration of each algorithm, plus the fix-up applied on the last one
    always_comb begin
        last_c      = (cnt_q == CW'(1));
        mul_add_c   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_acc_c   = {mul_add_c, acc_q[XLEN-1:1]};
        prod_fix_c  = (sign_a_q ^ sign_b_q) ? (2*XLEN)'(~mul_acc_c + (2*XLEN)'(1)) : mul_acc_c;
        mul_res_c   = (op_q[1:0] == 2'b00) ? prod_fix_c[XLEN-1:0] : prod_fix_c[2*XLEN-1:XLEN];

        div_shift_c = {rem_q, acc_q[XLEN-1]};
        div_ge_c    = (div_shift_c >= {1'b0, mcand_q});
        rem_c       = div_ge_c ? XLEN'(div_shift_c - {1'b0, mcand_q}) : div_shift_c[XLEN-1:0];
        quo_c       = {acc_q[XLEN-2:0], div_ge_c};
        div_res_c   = quo_c;
        if (op_q[1])
            div_res_c = sign_a_q ? XLEN'(~rem_c + XLEN'(1)) : rem_c;
        else if (sign_a_q ^ sign_b_q)
            div_res_c = XLEN'(~quo_c + XLEN'(1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept_c) begin
                if (!bus.op[2])               state_d = S_MUL;
                else if (div_zero_c || ovf_c) state_d = S_DONE;
                else                          state_d = S_DIV;
            end
            S_MUL, S_DIV: begin
                if (bus.flush)   state_d = S_IDLE;
                else if (last_c) state_d = S_DONE;
            end
            S_DONE: if (bus.flush || bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.busy      = 1'b1;
        bus.out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
            end
            S_DONE:  bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.result = result_q;
    assign bus.rd_out = rd_q;

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            rd_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept_c) begin
                    op_q     <= bus.op;
                    rd_q     <= bus.rd_in;
                    sign_a_q <= sgn_a_c;
                    sign_b_q <= sgn_b_c;
                    mcand_q  <= bus.op[2] ? mag_b_c : mag_a_c;
                    acc_q    <= {{XLEN{1'b0}}, (bus.op[2] ? mag_a_c : mag_b_c)};
                    rem_q    <= '0;
                    cnt_q    <= CW'(XLEN);
                    if (div_zero_c || ovf_c) result_q <= fast_res_c;
                end
                S_MUL: if (!bus.flush) begin
                    acc_q <= mul_acc_c;
                    cnt_q <= cnt_q - CW'(1);
                    if (last_c) result_q <= mul_res_c;
                end
                S_DIV: if (!bus.flush) begin
                    acc_q <= {{XLEN{1'b0}}, quo_c};
                    rem_q <= rem_c;
                    cnt_q <= cnt_q - CW'(1);
                    if (last_c) result_q <= div_res_c;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: arithmetic results, latency, handshake, flush and reset.
module tb_mdu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    mdu_seq_if #(.XLEN(32)) bus();

    mdu_seq #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request and let it be accepted on the next rising edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.src1     = a;
        bus.src2     = b;
        bus.rd_in    = rd;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = 3'($urandom);
        bus.src1     = $urandom;
        bus.src2     = $urandom;
        bus.rd_in    = 5'($urandom);
    endtask

    // Count cycles from the accept edge (inclusive) until out_valid, bounded
    task automatic wait_result(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(op, a, b, rd);
        wait_result(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, bus.result, exp);
        check({tag, "_rd"}, 32'(bus.rd_out), 32'(rd));
        consume();
        check({tag, "_idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    endtask

    initial begin
        int lat;
        logic [31:0] held_res;
        logic        stable;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.rd_in     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_rd_out", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33);
        run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 33);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 33);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 33);
        run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 33);
        run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 33);
        run_op("divu",   3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       33);
        run_op("remu",   3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        33);
        run_op("div0",   3'b100, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1);
        run_op("remu0",  3'b111, 32'd5,        32'd0,        5'd14, 32'd5,        1);
        run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1);
        run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1);

        // Result held while the consumer stalls, then back-to-back issue
        issue(3'b101, 32'd1000, 32'd10, 5'd21);
        wait_result(lat);
        check("hold_lat", 32'(lat), 32'd33);
        held_res = bus.result;
        check("hold_res", held_res, 32'd100);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.result !== 32'd100 || bus.rd_out !== 5'd21 || bus.in_ready !== 1'b0 ||
                bus.out_valid !== 1'b1)
                stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'd1);
        consume();
        check("hold_release", {30'd0, bus.in_ready, bus.busy}, 32'b10);
        issue(3'b000, 32'd3, 32'd4, 5'd22);
        check("b2b_accept", {30'd0, bus.in_ready, bus.busy}, 32'b01);
        wait_result(lat);
        check("b2b_res", bus.result, 32'd12);
        consume();

        // Flush during the twelfth iteration
        issue(3'b101, 32'd12345, 32'd3, 5'd23);
        repeat (11) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_idle", {29'd0, bus.in_ready, bus.busy, bus.out_valid}, 32'b100);
        stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) stable = 1'b0;
        end
        check("flush_no_result", 32'(stable), 32'd1);

        // Flush in IDLE blocks acceptance
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.op       = 3'b000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flush_idle_reject", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of a divide
        run_op("pre_rst", 3'b100, 32'd5, 32'd0, 5'd30, 32'hFFFFFFFF, 1);
        issue(3'b100, 32'd999, 32'd7, 5'd31);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #2;
        check("arst_state", {29'd0, bus.in_ready, bus.busy, bus.out_valid}, 32'b100);
        check("arst_result", bus.result, 32'd0);
        check("arst_rd_out", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", 3'b101, 32'd999, 32'd7, 5'd3, 32'd142, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
